// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter.
// State encoding and default sizing constants.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int ARB_N        = 8;
    localparam int ARB_MAX_HOLD = 16;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority pick: first requester at or after ptr,
// found by scanning the doubled request vector {req,req}.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N   = ARB_N,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] winner,
    output logic           any
);

    logic [2*N-1:0] req2;

    assign req2 = {req, req};

    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int k = 0; k < 2 * N; k++) begin
            if (!any && (k >= int'(ptr)) && req2[k]) begin
                any = 1'b1;
                // Upper copy maps back into 0..N-1
                if (k >= N) begin
                    winner = IDW'(k - N);
                end else begin
                    winner = IDW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with hold-until-done grant and
// optional forced release after MAX_HOLD cycles.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int IDW      = $clog2(N),
    parameter int MAX_HOLD = ARB_MAX_HOLD
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           timeout
);

    localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HCW-1:0] HOLD_LAST =
        (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;
    localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic           gnt_valid_q, gnt_valid_d;
    logic           timeout_q, timeout_d;

    logic [IDW-1:0] winner;
    logic           any;
    logic           own_req;
    logic           hit_max;
    logic           release_now;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any)
    );

    assign own_req     = req[owner_q];
    assign hit_max     = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
    assign release_now = done || !own_req || hit_max;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (any) begin
                    state_d     = ARB_GRANT;
                    owner_d     = winner;
                    gnt_d       = N'(1) << winner;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end
            end
            ARB_GRANT: begin
                if (release_now) begin
                    state_d     = ARB_IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    ptr_d       = (owner_q == LAST_ID) ? '0
                                : owner_q + IDW'(1);
                    // Voluntary release wins over the hold limit
                    timeout_d   = hit_max && !done && own_req;
                end else begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = owner_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter (MAX_HOLD=4): stimulus queues
// expected grants, a negedge monitor checks each grant and release.
module tb_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] req = '0;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    typedef struct {
        int id;
        int len;
        bit to;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    rr_arbiter #(
        .N        (8),
        .IDW      (3),
        .MAX_HOLD (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input int len, input bit to,
                        input int gap);
        exp_t e;
        e.id  = id;
        e.len = len;
        e.to  = to;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Monitor
    bit   prev_v = 1'b0;
    int   idle = 0;
    int   len = 0;
    int   cur_exp = -1;

    always @(negedge clk) begin
        exp_t e;
        chk("onehot0", int'($onehot0(gnt)), 1);
        if (gnt_valid && !prev_v) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_grant", int'(gnt_id), -1);
                cur_exp = -1;
            end else begin
                e = exp_q[0];
                chk("grant_id", int'(gnt_id), e.id);
                chk("grant_vec", int'(gnt), 1 << e.id);
                if (e.gap != 0) chk("idle_gap", idle, e.gap);
                cur_exp = e.id;
            end
            len = 1;
        end else if (gnt_valid) begin
            len++;
            chk("owner_stable", int'(gnt_id), cur_exp);
        end else if (prev_v) begin
            if (exp_q.size() == 0) begin
                chk("release_no_entry", 0, 1);
            end else begin
                e = exp_q.pop_front();
                if (e.len != 0) chk("hold_len", len, e.len);
                chk("timeout_flag", int'(timeout), int'(e.to));
            end
            idle = 1;
        end else begin
            idle++;
            chk("stray_timeout", int'(timeout), 0);
        end
        prev_v = gnt_valid;
    end

    initial begin
        // 1: reset with random requests
        #2 rst_n = 1'b0;
        req = 8'($urandom);
        tick();
        tick();
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_valid", int'(gnt_valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_id", int'(gnt_id), 0);
        req = '0;
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("idle_after_rst", int'(gnt_valid), 0);

        // 2: single request, done, then ptr moves to 3
        push(2, 3, 1'b0, 0);
        push(3, 1, 1'b0, 1);
        req = 8'h04;
        tick();
        tick();
        tick();
        done = 1'b1;
        req = 8'h00;
        tick();
        done = 1'b0;
        req = 8'h0C;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req = 8'h00;
        tick();

        // 3: full rotation with done after one cycle
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            push(i % 8, 1, 1'b0, (i == 0) ? 0 : 1);
        end
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
        end
        req = 8'h00;
        tick();
        tick();

        // 4: forced release after 4 cycles, then regrant
        push(4, 4, 1'b1, 0);
        push(4, 1, 1'b0, 1);
        req = 8'h10;
        repeat (6) tick();
        req = 8'h00;
        tick();
        tick();

        // 5: owner 5 drops request; then done coincides with limit
        push(5, 2, 1'b0, 0);
        req = 8'h20;
        tick();
        tick();
        req = 8'h00;
        tick();
        push(6, 4, 1'b0, 0);
        req = 8'h41;
        tick();
        tick();
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;

        // 6: reset in the middle of a grant to owner 6
        push(6, 0, 1'b0, 1);
        req = 8'h40;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_gnt", int'(gnt), 0);
        chk("async_valid", int'(gnt_valid), 0);
        chk("async_timeout", int'(timeout), 0);
        push(0, 1, 1'b0, 0);
        tick();
        req = 8'h81;
        rst_n = 1'b1;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req = 8'h00;
        repeat (3) tick();

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
